bcd_seg_display_driver: RTL and testbench
=========================================

// Module: bcd_seg_display_driver
// PURPOSE
//  Converts an unsigned binary value (e.g. metronome BPM) to NUM_DIGITS decimal digits and drives 7-segment codes.
//  Uses iterative double-dabble (shift-add-3), one bit per clock; no wide compare/subtract chains.
//  Sits between the BPM/tempo register and the board 7-segment displays.
//  Adds leading-zero blanking, an overflow indication and a load/done handshake.
// PARAMETERS
//  VALUE_W        9  width of the binary input value
//  NUM_DIGITS     3  number of decimal digits/displays driven (1..6)
//  BLANK_LEADING  1  1: blank leading zero digits (digit 0 always shown); 0: show all zeros
//  SEG_ACTIVE_LOW 1  1: segment lit = 0 (DE-board style); 0: lit = 1
// PORTS
//  clk       in   1               system clock, all state on rising edge
//  rst       in   1               asynchronous, active-high reset
//  value     in   VALUE_W         binary value; sampled only on the edge where load is accepted
//  load      in   1               conversion request; accepted when busy=0
//  busy      out  1               1 while a conversion is in progress
//  done      out  1               one-cycle pulse when seg/overflow have been updated
//  overflow  out  1               1: last converted value >= 10**NUM_DIGITS
//  seg       out  7*NUM_DIGITS    segment codes; digit k (k=0 least significant) at [7k+6:7k], bit order {g,f,e,d,c,b,a}
// BEHAVIOUR
//  Reset (async assert, sync release): state IDLE, busy=0, done=0, overflow=0, internal regs cleared;
//   seg = digit0 '0', other digits blank if BLANK_LEADING else '0'. Reset mid-conversion aborts, no done.
//  FSM IDLE -> SHIFT -> ENCODE -> IDLE.
//   IDLE: on load=1: capture value into shift reg, clear BCD reg (4*NUM_DIGITS bits), bit counter=VALUE_W, busy=1, go SHIFT.
//   SHIFT: each cycle, every BCD nibble >=5 gets +3, then {bcd,shift} shifted left 1. Counter decrements; after VALUE_W
//    shifts go ENCODE.
//   ENCODE: compute overflow = (captured value >= 10**NUM_DIGITS, elaboration-time constant; 0 if unreachable
//    for VALUE_W); register seg and overflow; done=1 for this one cycle's output; busy=0; go IDLE.
//  Latency: load accepted at edge E; seg/overflow/done valid after edge E+VALUE_W+1; busy high after E through
//   edge E+VALUE_W, low after E+VALUE_W+1. New load may be accepted in the cycle done is high (back-to-back).
//  load while busy=1 is ignored (no queueing); value changes while busy have no effect.
//  seg holds its last value between conversions; never shows intermediate BCD.
//  Digit encoding (active-high form, inverted when SEG_ACTIVE_LOW=1): 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F,
//   blank=00, dash=40 (segment g only).
//  Blanking: digit k>0 blank iff BLANK_LEADING=1 and digits k..NUM_DIGITS-1 are all zero. Digit 0 never blanked.
//  Overflow: all digits show dash, overflow=1 until next completed conversion; BCD truncation never displayed.
//  Arithmetic unsigned only; BCD add-3 per nibble is 4-bit, no carry into neighbour nibble.
// TESTING (defaults unless noted; active-low codes shown)
//  1 value=120, load 1 cycle -> done after 10 edges; seg={7'b1111001,7'b0100100,7'b1000000}, overflow=0.
//  2 value=7 -> digits2,1 = 7'b1111111 (blank), digit0 = 7'b1111000; BLANK_LEADING=0 -> digits2,1 = 7'b1000000.
//  3 NUM_DIGITS=2, value=100 -> overflow=1, both digits 7'b0111111; next load value=99 -> overflow=0, "99".
//  4 load=1 held 3 cycles starting with value=45, value changes to 300 mid-conversion -> single done, shows "45";
//    load pulsed on done cycle with 300 -> second done exactly VALUE_W+1 edges later, shows "300".
//  5 rst asserted at SHIFT cycle 4 (async, mid-cycle) -> busy=0 immediately, no done, seg = reset pattern.
//  6 sweep value 0..511 back-to-back vs reference model of decimal digits, blanking and overflow -> no mismatch.

Source files
------------

// File: rtl/bcd_seg_display_driver_if.sv
// bcd_seg_display_driver_if
//   Groups the value/load request and the busy/done/overflow/seg results of
//   bcd_seg_display_driver.
//   master: requester side (drives value, load; observes results)
//   slave : converter side (observes value, load; drives results)
//   value    VALUE_W       binary value to convert
//   load     1             conversion request
//   busy     1             conversion in progress
//   done     1             one-cycle pulse, seg/overflow updated
//   overflow 1             last value did not fit in NUM_DIGITS digits
//   seg      7*NUM_DIGITS  segment codes, digit k at [7k+6:7k], {g,f,e,d,c,b,a}
interface bcd_seg_display_driver_if #(
  parameter int VALUE_W    = 9,
  parameter int NUM_DIGITS = 3
);
  logic [VALUE_W-1:0]      value;
  logic                    load;
  logic                    busy;
  logic                    done;
  logic                    overflow;
  logic [7*NUM_DIGITS-1:0] seg;

  modport master (output value, load, input busy, done, overflow, seg);
  modport slave  (input value, load, output busy, done, overflow, seg);
endinterface

// File: rtl/bcd_seg_display_driver.sv
// bcd_seg_display_driver
//   Converts an unsigned binary value to NUM_DIGITS decimal digits with an
//   iterative double-dabble (one bit per clock) and drives 7-segment codes,
//   with optional leading-zero blanking and an all-dash overflow display.
//   clk  in  system clock, rising edge
//   rst  in  asynchronous active-high reset
//   bus  slave modport of bcd_seg_display_driver_if (value/load in,
//        busy/done/overflow/seg out)
//
//   state  | meaning
//   IDLE   | waiting for load; value captured on the accepting edge
//   SHIFT  | VALUE_W add-3/shift-left steps of the double-dabble
//   ENCODE | BCD final; register seg/overflow and pulse done
module bcd_seg_display_driver #(
  parameter int VALUE_W        = 9,
  parameter int NUM_DIGITS     = 3,
  parameter bit BLANK_LEADING  = 1'b1,
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst,
  bcd_seg_display_driver_if.slave  bus
);

  localparam int BCD_W = 4 * NUM_DIGITS;
  localparam int SEG_W = 7 * NUM_DIGITS;
  localparam int CNT_W = $clog2(VALUE_W + 1);
  // Compare in 64 bits so the limit is representable for any digit count;
  // for narrow VALUE_W the compare is simply never true.
  localparam logic [63:0] OVF_LIMIT = 64'(10 ** NUM_DIGITS);

  typedef enum logic [1:0] {IDLE, SHIFT, ENCODE} state_t;

  function automatic logic [6:0] digit_code(input logic [3:0] d);
    case (d)
      4'd0:    digit_code = 7'h3F;
      4'd1:    digit_code = 7'h06;
      4'd2:    digit_code = 7'h5B;
      4'd3:    digit_code = 7'h4F;
      4'd4:    digit_code = 7'h66;
      4'd5:    digit_code = 7'h6D;
      4'd6:    digit_code = 7'h7D;
      4'd7:    digit_code = 7'h07;
      4'd8:    digit_code = 7'h7F;
      4'd9:    digit_code = 7'h6F;
      default: digit_code = 7'h40;
    endcase
  endfunction

  // Walk from the most significant digit down; 'lead' stays set while every
  // digit seen so far is zero, which is exactly the blanking condition.
  function automatic logic [SEG_W-1:0] build_seg(input logic [BCD_W-1:0] bcd,
                                                 input logic ovf);
    logic [SEG_W-1:0] s;
    logic             lead;
    logic [6:0]       c;
    s    = '0;
    lead = BLANK_LEADING;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      if (ovf) begin
        c = 7'h40;
      end else if ((k != 0) && lead && (bcd[4*k +: 4] == 4'd0)) begin
        c = 7'h00;
      end else begin
        c    = digit_code(bcd[4*k +: 4]);
        lead = 1'b0;
      end
      s[7*k +: 7] = SEG_ACTIVE_LOW ? ~c : c;
    end
    return s;
  endfunction

  localparam logic [SEG_W-1:0] SEG_RESET = build_seg('0, 1'b0);

  state_t             state_q, state_d;
  logic [VALUE_W-1:0] value_q, value_d;
  logic [VALUE_W-1:0] shift_q, shift_d;
  logic [BCD_W-1:0]   bcd_q, bcd_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [SEG_W-1:0]   seg_q, seg_d;
  logic               overflow_q, overflow_d;
  logic               done_q, done_d;

  logic [BCD_W-1:0]   bcd_adj;
  logic               ovf_now;

  assign ovf_now = (64'(value_q) >= OVF_LIMIT);

  always_comb begin
    bcd_adj = bcd_q;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (bcd_q[4*k +: 4] >= 4'd5) bcd_adj[4*k +: 4] = bcd_q[4*k +: 4] + 4'd3;
    end
  end

  always_comb begin
    state_d    = state_q;
    value_d    = value_q;
    shift_d    = shift_q;
    bcd_d      = bcd_q;
    cnt_d      = cnt_q;
    seg_d      = seg_q;
    overflow_d = overflow_q;
    done_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.load) begin
          value_d = bus.value;
          shift_d = bus.value;
          bcd_d   = '0;
          cnt_d   = CNT_W'(VALUE_W);
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        {bcd_d, shift_d} = {bcd_adj[BCD_W-2:0], shift_q, 1'b0};
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = ENCODE;
      end
      ENCODE: begin
        overflow_d = ovf_now;
        seg_d      = build_seg(bcd_q, ovf_now);
        done_d     = 1'b1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      value_q    <= '0;
      shift_q    <= '0;
      bcd_q      <= '0;
      cnt_q      <= '0;
      seg_q      <= SEG_RESET;
      overflow_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      value_q    <= value_d;
      shift_q    <= shift_d;
      bcd_q      <= bcd_d;
      cnt_q      <= cnt_d;
      seg_q      <= seg_d;
      overflow_q <= overflow_d;
      done_q     <= done_d;
    end
  end

  assign bus.busy     = (state_q != IDLE);
  assign bus.done     = done_q;
  assign bus.overflow = overflow_q;
  assign bus.seg      = seg_q;

endmodule

// File: tb/tb_bcd_seg_display_driver.sv
// tb_bcd_seg_display_driver
//   Drives three converter configurations from one value/load stream:
//   d0: 3 digits, blanking, active-low; d1: 3 digits, no blanking,
//   active-high; d2: 2 digits, blanking, active-low.
module tb_bcd_seg_display_driver;
  logic       clk = 1'b0;
  logic       rst;
  logic [8:0] value;
  logic       load;
  int         total = 0;
  int         bad   = 0;
  bit         busy_ok;

  always #5 clk = ~clk;

  bcd_seg_display_driver_if #(.VALUE_W(9), .NUM_DIGITS(3)) b0 ();
  bcd_seg_display_driver_if #(.VALUE_W(9), .NUM_DIGITS(3)) b1 ();
  bcd_seg_display_driver_if #(.VALUE_W(9), .NUM_DIGITS(2)) b2 ();

  assign b0.value = value;
  assign b0.load  = load;
  assign b1.value = value;
  assign b1.load  = load;
  assign b2.value = value;
  assign b2.load  = load;

  bcd_seg_display_driver #(.VALUE_W(9), .NUM_DIGITS(3), .BLANK_LEADING(1'b1), .SEG_ACTIVE_LOW(1'b1))
    dut0 (.clk(clk), .rst(rst), .bus(b0));
  bcd_seg_display_driver #(.VALUE_W(9), .NUM_DIGITS(3), .BLANK_LEADING(1'b0), .SEG_ACTIVE_LOW(1'b0))
    dut1 (.clk(clk), .rst(rst), .bus(b1));
  bcd_seg_display_driver #(.VALUE_W(9), .NUM_DIGITS(2), .BLANK_LEADING(1'b1), .SEG_ACTIVE_LOW(1'b1))
    dut2 (.clk(clk), .rst(rst), .bus(b2));

  function automatic logic [6:0] digit_font(input int d);
    case (d)
      0: return 7'h3F;  1: return 7'h06;  2: return 7'h5B;  3: return 7'h4F;
      4: return 7'h66;  5: return 7'h6D;  6: return 7'h7D;  7: return 7'h07;
      8: return 7'h7F;  default: return 7'h6F;
    endcase
  endfunction

  function automatic int pow10(input int n);
    int p = 1;
    for (int i = 0; i < n; i++) p = p * 10;
    return p;
  endfunction

  // Display expected for value v: decimal digit k is (v / 10^k) % 10; a
  // digit above 0 is a leading zero exactly when v < 10^k.
  function automatic logic [20:0] model_seg(input int v, input int nd,
                                            input bit blank, input bit alow);
    logic [20:0] r = '0;
    logic [6:0]  c;
    for (int k = 0; k < nd; k++) begin
      if (v >= pow10(nd))                 c = 7'h40;
      else if (k > 0 && blank && v < pow10(k)) c = 7'h00;
      else                                c = digit_font((v / pow10(k)) % 10);
      r[7*k +: 7] = alow ? ~c : c;
    end
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input int v, input string tag);
    check({tag, "_d0_seg"}, 32'(b0.seg), 32'(model_seg(v, 3, 1'b1, 1'b1)));
    check({tag, "_d1_seg"}, 32'(b1.seg), 32'(model_seg(v, 3, 1'b0, 1'b0)));
    check({tag, "_d2_seg"}, 32'(b2.seg), 32'(model_seg(v, 2, 1'b1, 1'b1)));
    check({tag, "_ovf"}, {29'd0, b0.overflow, b1.overflow, b2.overflow},
          {29'd0, 1'(v >= 1000), 1'(v >= 1000), 1'(v >= 100)});
  endtask

  // Presents a load for one edge; 'sync' aligns to a falling edge first,
  // otherwise it is issued right away (used on a done cycle).
  task automatic start(input int v, input bit sync);
    if (sync) @(negedge clk);
    value = 9'(v);
    load  = 1'b1;
    @(posedge clk);
    #1;
    load    = 1'b0;
    busy_ok = b0.busy && b1.busy && b2.busy;
  endtask

  // Counts edges until done; junk=1 scribbles value/load while busy.
  task automatic wait_done(input int exp_edges, input bit junk, input string tag);
    int n = 0;
    bit seen = 1'b0;
    while (!seen && n < 40) begin
      @(posedge clk);
      #1;
      n++;
      if (b0.done) seen = 1'b1;
      else begin
        if (!(b0.busy && b1.busy && b2.busy)) busy_ok = 1'b0;
        if (junk) begin
          value = 9'($urandom_range(0, 511));
          load  = 1'($urandom_range(0, 1));
        end
      end
    end
    load = 1'b0;
    check({tag, "_latency"}, 32'(n), 32'(exp_edges));
    check({tag, "_busy_hi"}, {31'd0, busy_ok}, 32'd1);
    check({tag, "_done_busy"}, {26'd0, b0.done, b1.done, b2.done, b0.busy, b1.busy, b2.busy},
          32'b111000);
  endtask

  initial begin
    int v;
    int gap;
    bit no_done;
    rst   = 1'b1;
    load  = 1'b0;
    value = '0;
    #12;
    check("reset_ctl", {29'd0, b0.busy, b0.done, b0.overflow}, 32'd0);
    check_all(0, "reset");
    @(negedge clk);
    rst = 1'b0;

    // 120: exact active-low codes as well as the model
    start(120, 1'b1);
    wait_done(10, 1'b0, "t1");
    check("t1_exact", 32'(b0.seg), 32'({7'b1111001, 7'b0100100, 7'b1000000}));
    check_all(120, "t1");
    @(posedge clk);
    #1;
    check("t1_done_pulse", {31'd0, b0.done}, 32'd0);

    start(7, 1'b1);
    wait_done(10, 1'b1, "t2");
    check("t2_exact", 32'(b0.seg), 32'({7'b1111111, 7'b1111111, 7'b1111000}));
    check_all(7, "t2");

    start(100, 1'b1);
    wait_done(10, 1'b1, "t3a");
    check("t3a_exact", 32'(b2.seg), 32'({7'b0111111, 7'b0111111}));
    check_all(100, "t3a");
    start(99, 1'b0);
    wait_done(10, 1'b1, "t3b");
    check("t3b_exact", 32'(b2.seg), 32'({7'b0010000, 7'b0010000}));
    check_all(99, "t3b");

    // load held three cycles while value changes to 300 mid-conversion
    @(negedge clk);
    value = 9'd45;
    load  = 1'b1;
    @(posedge clk);
    #1;
    busy_ok = b0.busy;
    @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    value = 9'd300;
    @(posedge clk);
    @(negedge clk);
    load = 1'b0;
    wait_done(8, 1'b0, "t4a");
    check_all(45, "t4a");
    start(300, 1'b0);
    wait_done(10, 1'b0, "t4b");
    check_all(300, "t4b");

    // async reset four edges into the shift phase
    start(123, 1'b1);
    repeat (3) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("t5_ctl", {29'd0, b0.busy, b0.done, b2.overflow}, 32'd0);
    check_all(0, "t5");
    @(negedge clk);
    rst = 1'b0;
    no_done = 1'b1;
    repeat (15) begin
      @(posedge clk);
      #1;
      if (b0.done || b0.busy) no_done = 1'b0;
    end
    check("t5_no_done", {31'd0, no_done}, 32'd1);

    // full sweep, back-to-back, with scribbling while busy
    start(0, 1'b1);
    for (int i = 0; i < 512; i++) begin
      wait_done(10, 1'b1, $sformatf("sw%0d", i));
      check_all(i, $sformatf("sw%0d", i));
      if (i < 511) start(i + 1, 1'b0);
    end

    // random values with random idle gaps
    for (int i = 0; i < 30; i++) begin
      v   = int'($urandom_range(0, 511));
      gap = int'($urandom_range(0, 3));
      if (gap == 0) start(v, 1'b0);
      else begin
        repeat (gap) @(posedge clk);
        start(v, 1'b1);
      end
      wait_done(10, 1'b1, $sformatf("rnd%0d", i));
      check_all(v, $sformatf("rnd%0d", i));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
